// File: rtl/imem_param.sv
// Loadable instruction memory: fills every word with FILL_WORD after reset,
// then serves word-aligned reads (1-cycle latency) and byte-enabled writes.
module imem_param #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          ADDR_W    = 7,
  parameter int unsigned          DEPTH     = 32,
  parameter logic [DATA_W-1:0]    FILL_WORD = DATA_W'(32'h00000013)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   mem_in,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   mem_out,
  output logic                mem_valid,
  output logic                addr_err,
  output logic                init_done
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned LSB = $clog2(NB);
  localparam int unsigned IW  = ADDR_W - LSB;
  localparam int unsigned IW1 = IW + 1;
  localparam int unsigned CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IW:0]   DEPTH_C = IW1'(DEPTH);
  localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [IW-1:0]       idx;
  logic [CW-1:0]       midx;
  logic                misaligned;
  logic                out_of_range;
  logic                bad;
  logic                wr_act;
  logic                rd_ok;
  logic                wr_ok;

  logic [DATA_W-1:0]   mem_out_d;
  logic                mem_valid_d;
  logic                addr_err_d;

  // Address decode
  assign idx          = address[ADDR_W-1:LSB];
  assign midx         = idx[CW-1:0];
  assign misaligned   = |address[LSB-1:0];
  assign out_of_range = ({1'b0, idx} >= DEPTH_C);
  assign bad          = misaligned | out_of_range;

  // A write with no lanes enabled is a no-op and cannot raise an error
  assign wr_act = memWrite & (|byte_en);
  assign rd_ok  = (state_q == RUN) & memRead & ~bad;
  assign wr_ok  = (state_q == RUN) & wr_act  & ~bad;

  assign init_done = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_out_d   = '0;
    mem_valid_d = 1'b0;
    addr_err_d  = 1'b0;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (rd_ok) begin
          mem_out_d   = mem[midx];
          mem_valid_d = 1'b1;
        end
        addr_err_d = (memRead | wr_act) & bad;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_out   <= '0;
      mem_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      mem_out   <= mem_out_d;
      mem_valid <= mem_valid_d;
      addr_err  <= addr_err_d;
    end
  end

  // Storage is not reset; the INIT fill overwrites every word instead
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= FILL_WORD;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[midx][8*i +: 8] <= mem_in[8*i +: 8];
      end
    end
  end

endmodule
